counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_pkg.sv | 10 +
 rtl/bcd_digit.sv | 36 +++
 rtl/counter.sv | 61 ++++++
 tb/tb_counter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared digit limits for the BCD stopwatch.
// Each value is the last count a digit reaches before it wraps to zero.
package counter_pkg;

  localparam int unsigned TenthsMax   = 9;
  localparam int unsigned SecUnitsMax = 9;
  localparam int unsigned SecTensMax  = 5;
  localparam int unsigned MinutesMax  = 9;

endpackage

// File: rtl/bcd_digit.sv
// One wrapping decimal digit register with a carry out to the next digit.
// The digit counts 0..MAX and carry is high on the tick that wraps it.
module bcd_digit #(
  parameter int unsigned MAX = 9
) (
  input  logic       clk,
  input  logic       r,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  localparam logic [3:0] MaxVal = 4'(MAX);

  logic [3:0] digit_q, digit_d;

  // Using >= means an out-of-range value goes back to zero instead of stepping through A-F.
  always_comb begin
    digit_d = digit_q;
    if (inc) begin
      digit_d = (digit_q >= MaxVal) ? 4'd0 : digit_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign carry = inc & (digit_q == MaxVal);

endmodule

// File: rtl/counter.sv
// BCD stopwatch with a range of 0:00.0 to 9:59.9.
// Four digits are chained through combinational carries, so every digit updates on the same edge.
module counter
  import counter_pkg::*;
(
  input  logic       clk,
  input  logic       r,
  input  logic       en,
  output logic [3:0] q0,
  output logic [7:0] qs,
  output logic [3:0] qm
);

  logic       c_tenths, c_sec_units, c_sec_tens;
  logic       unused_min_carry;
  logic [3:0] sec_units, sec_tens;

  bcd_digit #(
    .MAX(TenthsMax)
  ) u_tenths (
    .clk  (clk),
    .r    (r),
    .inc  (en),
    .digit(q0),
    .carry(c_tenths)
  );

  bcd_digit #(
    .MAX(SecUnitsMax)
  ) u_sec_units (
    .clk  (clk),
    .r    (r),
    .inc  (c_tenths),
    .digit(sec_units),
    .carry(c_sec_units)
  );

  bcd_digit #(
    .MAX(SecTensMax)
  ) u_sec_tens (
    .clk  (clk),
    .r    (r),
    .inc  (c_sec_units),
    .digit(sec_tens),
    .carry(c_sec_tens)
  );

  // The minute carry has nowhere to go. A full wrap returns the count to 0:00.0 without a flag.
  bcd_digit #(
    .MAX(MinutesMax)
  ) u_minutes (
    .clk  (clk),
    .r    (r),
    .inc  (c_sec_tens),
    .digit(qm),
    .carry(unused_min_carry)
  );

  assign qs = {sec_tens, sec_units};

endmodule

// File: tb/tb_counter.sv
// Randomised self-checking bench for the BCD stopwatch.
// The reference model keeps a plain count of tenths and works out each digit by division.
module tb_counter;

  logic       clk;
  logic       r;
  logic       en;
  logic [3:0] q0;
  logic [7:0] qs;
  logic [3:0] qm;

  int total;
  int bad;
  int cnt;

  counter dut (
    .clk(clk),
    .r  (r),
    .en (en),
    .q0 (q0),
    .qs (qs),
    .qm (qm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model_val(input int c);
    int t, s, m;
    t = c % 10;
    s = (c / 10) % 60;
    m = (c / 600) % 10;
    return {4'(m), 4'(s / 10), 4'(s % 10), 4'(t)};
  endfunction

  function automatic logic [15:0] dut_val();
    return {qm, qs, q0};
  endfunction

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (m:ss.t as m_ss_t)", tag, got, exp);
    end
  endtask

  // Entered about 1ns after a rising edge. Drives en, waits for the next edge, then checks.
  task automatic step(input logic e);
    en = e;
    @(posedge clk);
    if (r && e) cnt = (cnt + 1) % 6000;
    #1;
    check("step", dut_val(), model_val(cnt));
  endtask

  task automatic pulses(input int n, input int idle);
    for (int i = 0; i < n; i++) begin
      step(1'b1);
      for (int k = 0; k < idle; k++) step(1'b0);
    end
  endtask

  // Asserts reset mid-period and checks the clear happens before the next edge.
  task automatic mid_reset();
    #3;
    r = 1'b0;
    #1;
    cnt = 0;
    check("async_clear", dut_val(), 16'h0000);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    #2;
    r = 1'b1;
    #1;
    check("release", dut_val(), 16'h0000);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cnt   = 0;
    r     = 1'b0;
    en    = 1'b0;
    #2;
    check("reset_async", dut_val(), 16'h0000);
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) step(1'(i % 2));
    #2;
    r = 1'b1;

    // Count part of the way, then clear in the middle of a clock period.
    pulses(7, 0);
    mid_reset();

    pulses(9, 1);
    check("units_9", dut_val(), 16'h0009);
    pulses(1, 1);
    check("units_10", dut_val(), 16'h0010);

    mid_reset();
    pulses(599, 1);
    check("min_599", dut_val(), 16'h0599);
    pulses(1, 1);
    check("min_600", dut_val(), 16'h1000);

    mid_reset();
    pulses(620, 3);
    check("long_620", dut_val(), 16'h1020);

    mid_reset();
    pulses(5999, 0);
    check("full_5999", dut_val(), 16'h9599);
    pulses(1, 0);
    check("full_6000", dut_val(), 16'h0000);

    mid_reset();
    pulses(834, 0);
    check("at_1234", dut_val(), 16'h1234);
    mid_reset();
    pulses(3, 0);
    check("resume", dut_val(), 16'h0003);

    // Random enable pattern, with an occasional asynchronous reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) mid_reset();
      step(1'($urandom_range(0, 3) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
